// File: rtl/mult_hilo_unit_pkg.sv
// rtl/mult_hilo_unit_pkg.sv - shared defaults and FSM encoding for the HI/LO multiplier
package mult_hilo_unit_pkg;

   localparam int MULT_WIDTH = 32;
   localparam int MULT_CNT_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } mult_state_e;

endpackage

// File: rtl/mult_shift_add_core.sv
// rtl/mult_shift_add_core.sv - radix-2 shift-add datapath operating on unsigned magnitudes
module mult_shift_add_core
   import mult_hilo_unit_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = MULT_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic [2*WIDTH-1:0] product,
   output logic               last
);

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mplier_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   addend;
   logic [WIDTH:0]   sum;

   // The carry out of the add becomes the new accumulator MSB after the shift.
   always_comb begin
      addend = mplier_q[0] ? {1'b0, mcand_q} : '0;
      sum    = {1'b0, acc_q} + addend;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (load) begin
         mcand_q  <= mcand;
         acc_q    <= '0;
         mplier_q <= mplier;
         cnt_q    <= '0;
      end else if (step) begin
         acc_q    <= sum[WIDTH:1];
         mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
         cnt_q    <= cnt_q + CNT_W'(1);
      end
   end

   assign product = {acc_q, mplier_q};
   assign last    = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - multi-cycle MULT/MULTU unit holding the product in HI/LO
module mult_hilo_unit
   import mult_hilo_unit_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = MULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_mult,
   input  logic             mult_sign,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   mult_state_e        state_q;
   logic               neg_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_d;
   logic [WIDTH-1:0]   lo_d;
   logic               load;
   logic               step;
   logic [WIDTH-1:0]   mcand_abs;
   logic [WIDTH-1:0]   mplier_abs;
   logic [2*WIDTH-1:0] core_product;
   logic               core_last;
   logic [2*WIDTH-1:0] signed_product;

   // The most-negative operand negates to itself, which is its correct unsigned magnitude.
   always_comb begin
      load           = (state_q == ST_IDLE) && start_mult;
      step           = (state_q == ST_RUN);
      mcand_abs      = (mult_sign && rs_data[WIDTH-1]) ? -rs_data : rs_data;
      mplier_abs     = (mult_sign && rt_data[WIDTH-1]) ? -rt_data : rt_data;
      signed_product = neg_q ? -core_product : core_product;
      hi_d           = signed_product[2*WIDTH-1:WIDTH];
      lo_d           = signed_product[WIDTH-1:0];
   end

   mult_shift_add_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .step    (step),
      .mcand   (mcand_abs),
      .mplier  (mplier_abs),
      .product (core_product),
      .last    (core_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_mult) begin
                  neg_q   <= mult_sign & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (core_last) state_q <= ST_FIN;
            end
            ST_FIN: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign done = done_q;
   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - self-checking bench for mult_hilo_unit
module tb_mult_hilo_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_mult;
   logic        mult_sign;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [31:0] rs;
      logic [31:0] rt;
      logic        sgn;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t        vecs [9];
   logic [31:0] corners [4];

   always #5 clk = ~clk;

   mult_hilo_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start_mult (start_mult),
      .mult_sign  (mult_sign),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa;
      longint sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return 64'(a) * 64'(b);
   endfunction

   // Called at the negedge following the accept edge; returns at the negedge where done is seen.
   task automatic wait_done(output int busy_cycles, output bit seen);
      busy_cycles = 0;
      seen        = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eh, input logic [31:0] el);
      int bc;
      bit seen;
      @(negedge clk);
      rs_data = a; rt_data = b; mult_sign = s; start_mult = 1'b1;
      @(negedge clk);
      start_mult = 1'b0;
      rs_data    = $urandom;
      rt_data    = $urandom;
      mult_sign  = ~s;
      wait_done(bc, seen);
      check({name, " done_seen"}, 64'(seen), 64'd1);
      check({name, " busy_cycles"}, 64'(bc), 64'd33);
      check({name, " hi"}, 64'(hi), 64'(eh));
      check({name, " lo"}, 64'(lo), 64'(el));
      @(negedge clk);
      check({name, " done_width"}, 64'(done), 64'd0);
   endtask

   initial begin
      int bc;
      bit seen;
      int dcount;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] p;

      vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
      vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000};
      vecs[4] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h0000_0000};
      vecs[5] = '{32'h0000_0007, 32'h0000_0006, 1'b0, 32'h0000_0000, 32'h0000_002A};
      vecs[6] = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000};
      vecs[8] = '{32'h1234_5678, 32'h0000_0001, 1'b0, 32'h0000_0000, 32'h1234_5678};
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'h8000_0000;
      corners[3] = 32'hFFFF_FFFF;

      rst = 1'b1; start_mult = 1'b0; mult_sign = 1'b0; rs_data = '0; rt_data = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);

      for (int i = 0; i < 9; i++)
         run_op($sformatf("vec%0d", i), vecs[i].rs, vecs[i].rt, vecs[i].sgn, vecs[i].hi, vecs[i].lo);

      // A second start while busy must be ignored.
      @(negedge clk);
      rs_data = 32'd7; rt_data = 32'd6; mult_sign = 1'b0; start_mult = 1'b1;
      @(negedge clk);
      start_mult = 1'b0;
      bc = 0; seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) bc++;
         if (i == 9) begin
            rs_data = 32'd3; rt_data = 32'd3; start_mult = 1'b1;
         end else begin
            start_mult = 1'b0;
         end
         @(negedge clk);
      end
      start_mult = 1'b0;
      check("ignore done_seen", 64'(seen), 64'd1);
      check("ignore busy_cycles", 64'(bc), 64'd33);
      check("ignore hi", 64'(hi), 64'd0);
      check("ignore lo", 64'(lo), 64'd42);
      @(negedge clk);
      check("ignore no_restart", 64'(busy), 64'd0);

      // Back-to-back: new start issued in the done cycle.
      rs_data = 32'd5; rt_data = 32'd5; mult_sign = 1'b0; start_mult = 1'b1;
      @(negedge clk);
      start_mult = 1'b0;
      wait_done(bc, seen);
      check("b2b first done_seen", 64'(seen), 64'd1);
      check("b2b first hi", 64'(hi), 64'd0);
      check("b2b first lo", 64'(lo), 64'd25);
      rs_data = 32'hFFFF_FFFE; rt_data = 32'd3; mult_sign = 1'b1; start_mult = 1'b1;
      @(negedge clk);
      start_mult = 1'b0;
      check("b2b second accepted", 64'(busy), 64'd1);
      check("b2b hold lo", 64'(lo), 64'd25);
      wait_done(bc, seen);
      check("b2b second done_seen", 64'(seen), 64'd1);
      check("b2b second busy_cycles", 64'(bc), 64'd33);
      check("b2b second hi", 64'(hi), 64'hFFFF_FFFF);
      check("b2b second lo", 64'(lo), 64'hFFFF_FFFA);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      rs_data = 32'd9; rt_data = 32'd11; mult_sign = 1'b0; start_mult = 1'b1;
      @(negedge clk);
      start_mult = 1'b0;
      repeat (15) @(negedge clk);
      check("midrst busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("midrst hi", 64'(hi), 64'd0);
      check("midrst lo", 64'(lo), 64'd0);
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 50; i++) begin
         if (done || busy) dcount++;
         @(negedge clk);
      end
      check("midrst quiet", 64'(dcount), 64'd0);
      run_op("after_rst", 32'd123, 32'hFFFF_FFF6, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FB32);

      for (int n = 0; n < 30; n++) begin
         a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
         b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
         s = 1'($urandom_range(0, 1));
         p = ref_product(a, b, s);
         run_op($sformatf("rand%0d", n), a, b, s, p[63:32], p[31:0]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
